// File: rtl/cipher_output_collector_if.sv
// Ciphertext output stream: one unmasked 128-bit block per valid/ready transfer.
interface cipher_output_collector_if #(
    parameter int DATA_W = 32
);
    logic [4*DATA_W-1:0] ct_data;
    logic                ct_valid;
    logic                ct_ready;

    modport master (output ct_data, output ct_valid, input ct_ready);
    modport slave  (input ct_data, input ct_valid, output ct_ready);
endinterface

// File: rtl/cipher_output_collector.sv
// Collects four masked ciphertext words after a done edge, unmasks them and buffers the block.
// Define COLLECT_FIFO_EN for a 2-entry output FIFO; otherwise a single output register is used.
module cipher_output_collector #(
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         OutputData0,
    input  logic [DATA_W-1:0]         OutputData1,
    input  logic                      done,
    cipher_output_collector_if.master ct,
    output logic                      busy,
    output logic                      overflow
);
    localparam int BLOCK_W = 4 * DATA_W;

    typedef enum logic {IDLE, COLLECT} state_t;

    function automatic logic [DATA_W-1:0] unmask(input logic [DATA_W-1:0] s0,
                                                 input logic [DATA_W-1:0] s1);
        return s0 ^ s1;
    endfunction

    state_t                state;
    logic [1:0]            cnt;
    logic                  done_q;
    logic [3*DATA_W-1:0]   asm_p0;
    logic [DATA_W-1:0]     word;
    logic [BLOCK_W-1:0]    block;
    logic                  start;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  accept;

    assign word    = unmask(OutputData0, OutputData1);
    assign start   = done & ~done_q;
    assign capture = (state == IDLE && start) || (state == COLLECT && cnt != 2'd3);
    assign push    = (state == COLLECT) && (cnt == 2'd3);
    // The fourth word goes straight into the block; the first three are shifted in MSB-first.
    assign block   = {asm_p0, word};
    assign pop     = ct.ct_valid & ct.ct_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            done_q <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done_q <= done;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        cnt   <= 2'd1;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    // Counter wraps 3 -> 0 on the final capture edge.
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ---- stage p0: word assembly ----
    always_ff @(posedge clk) begin
        if (capture) asm_p0 <= {asm_p0[2*DATA_W-1:0], word};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else if ((state == COLLECT && start) || (push && !accept)) overflow <= 1'b1;
    end

`ifdef COLLECT_FIFO_EN
    logic [BLOCK_W-1:0] mem [2];
    logic               rd_ptr;
    logic [1:0]         count;

    // A pop on the same edge frees the slot the write index points at when full.
    assign accept      = push && (count != 2'd2 || pop);
    assign ct.ct_valid = (count != 2'd0);
    assign ct.ct_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) mem[rd_ptr ^ count[0]] <= block;
            if (pop) rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [BLOCK_W-1:0] buf_data;
    logic               buf_valid;

    assign accept      = push && (!buf_valid || pop);
    assign ct.ct_valid = buf_valid;
    assign ct.ct_data  = buf_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else if (accept) begin
            buf_data  <= block;
            buf_valid <= 1'b1;
        end else if (pop) begin
            buf_valid <= 1'b0;
        end
    end
`endif

endmodule
